// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences single-word ram2 accesses from MAR/MDR on behalf of the datapath
// Ports:
//   clk, clr        clock, async active-low reset
//   busIn           datapath bus; marIn/mdrIn load MAR (low ADDR bits) / MDR in IDLE
//   memRead/Write   one-cycle access requests, honoured only in IDLE
//   mdrOut          MDR contents
//   busy/done/err   access in progress / completion pulse / illegal-request pulse
//   ramAddr/DataIn  MAR/MDR towards ram2; ramRead/ramWrite one-cycle strobes
//   ramDataOut      ram2 read data, valid the cycle after ramRead is sampled
module mem_ctrl #(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [BITS-1:0] busIn,
  input  logic            marIn,
  input  logic            mdrIn,
  input  logic            memRead,
  input  logic            memWrite,
  output logic [BITS-1:0] mdrOut,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR-1:0] ramAddr,
  output logic [BITS-1:0] ramDataIn,
  output logic            ramRead,
  output logic            ramWrite,
  input  logic [BITS-1:0] ramDataOut
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
  state_t          state_q;
  logic [ADDR-1:0] mar_q;
  logic [BITS-1:0] mdr_q;
  logic            busy_q, done_q, err_q, rd_q, wr_q;
  // Outputs are registered alongside the state, so each one is set on the edge entering its state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A register load takes the edge; a request in the same cycle is dropped.
          if (marIn || mdrIn) begin
            if (marIn) mar_q <= busIn[ADDR-1:0];
            if (mdrIn) mdr_q <= busIn;
          end else if (memRead && !memWrite) begin
            state_q <= RD;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (memWrite && !memRead) begin
            state_q <= WR;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (memRead && memWrite) begin
            err_q <= 1'b1;
          end
        end
        RD: state_q <= RD_WAIT;
        RD_WAIT: begin
          mdr_q   <= ramDataOut;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        WR: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign mdrOut    = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ramAddr   = mar_q;
  assign ramDataIn = mdr_q;
  assign ramRead   = rd_q;
  assign ramWrite  = wr_q;
endmodule
